// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready
// handshake, optional two-entry skid buffer, freeze (stall) and flush (squash).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   freeze          stall: blocks push and pop, holds all state
//   flush           squash: drops all held entries (priority over freeze)
//   in_valid/ready  upstream handshake, in_data payload
//   out_valid/ready downstream handshake, out_data = main entry payload
//   count           entries held (0..2)
//   discard_cnt     saturating total of entries dropped by flush
module pipe_stage_reg #(
  parameter int unsigned       WIDTH     = 64,
  parameter bit                SKID_EN   = 1'b1,
  parameter logic [WIDTH-1:0]  RST_VALUE = '0,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] discard_cnt
);

  localparam int unsigned      SUM_W   = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] disc_sum;

  // State and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_VALUE;
      skid_q  <= RST_VALUE;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      disc_q  <= disc_d;
    end
  end

  // Output decode; with the skid buffer in_ready comes from state only,
  // without it a pop in the same cycle frees the single entry.
  always_comb begin
    out_valid   = (state_q != ST_EMPTY);
    out_data    = main_q;
    discard_cnt = disc_q;
    case (state_q)
      ST_ONE:  count = 2'd1;
      ST_FULL: count = 2'd2;
      default: count = 2'd0;
    endcase
    if (SKID_EN) begin
      in_ready = (state_q != ST_FULL);
    end else begin
      in_ready = ~out_valid | (out_ready & ~freeze);
    end
  end

  // Next-state and data-path selection; flush > freeze > handshake
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    disc_d   = disc_q;
    push     = in_valid & in_ready & ~freeze & ~flush;
    pop      = out_valid & out_ready & ~freeze & ~flush;
    disc_sum = SUM_W'(disc_q) + SUM_W'(count);

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RST_VALUE;
      skid_d  = RST_VALUE;
      disc_d  = (disc_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : disc_sum[CNT_W-1:0];
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push && SKID_EN) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // skid entry moves up behind the departing main entry
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: drives a skid (SKID_EN=1) and a single-entry
// (SKID_EN=0) instance with identical stimulus and compares both against
// queue-based reference models.
module tb_pipe_stage_reg;

  localparam int unsigned      W    = 16;
  localparam int unsigned      CW   = 8;
  localparam logic [W-1:0]     RV   = 16'hDEAD;
  localparam int               CMAX = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic         freeze;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [1:0]   count1;
  logic [CW-1:0] disc1_o;

  logic         in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   count0;
  logic [CW-1:0] disc0_o;

  int checks = 0;
  int errors = 0;

  // reference model: queue of held payloads, last shown payload, discard total
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] sh1, sh0;
  int           dc1, dc0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .SKID_EN(1'b1), .RST_VALUE(RV), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
    .count(count1), .discard_cnt(disc1_o)
  );

  pipe_stage_reg #(.WIDTH(W), .SKID_EN(1'b0), .RST_VALUE(RV), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready),
    .count(count0), .discard_cnt(disc0_o)
  );

  task automatic model_reset();
    q1.delete();
    q0.delete();
    sh1 = RV;
    sh0 = RV;
    dc1 = 0;
    dc0 = 0;
  endtask

  function automatic bit m_rdy1();
    return q1.size() < 2;
  endfunction

  function automatic bit m_rdy0();
    return (q0.size() == 0) || (out_ready && !freeze);
  endfunction

  task automatic set_in(input bit iv, input logic [W-1:0] d, input bit ordy,
                        input bit frz, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    freeze    = frz;
    flush     = fl;
  endtask

  // one clock edge; the model updates from the inputs present before the edge
  task automatic tick();
    bit p1, o1, p0, o0;
    p1 = in_valid && m_rdy1() && !freeze && !flush;
    o1 = (q1.size() > 0) && out_ready && !freeze && !flush;
    p0 = in_valid && m_rdy0() && !freeze && !flush;
    o0 = (q0.size() > 0) && out_ready && !freeze && !flush;
    @(posedge clk);
    if (flush) begin
      dc1 = (dc1 + q1.size() > CMAX) ? CMAX : dc1 + q1.size();
      dc0 = (dc0 + q0.size() > CMAX) ? CMAX : dc0 + q0.size();
      q1.delete();
      q0.delete();
      sh1 = RV;
      sh0 = RV;
    end else begin
      if (o1) void'(q1.pop_front());
      if (p1) q1.push_back(in_data);
      if (q1.size() > 0) sh1 = q1[0];
      if (o0) void'(q0.pop_front());
      if (p0) q0.push_back(in_data);
      if (q0.size() > 0) sh0 = q0[0];
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid1 got %b exp 0", out_valid1); end
    checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL reset_count1 got %0d exp 0", count1); end
    checks++; if (disc1_o !== 8'd0) begin errors++; $display("FAIL reset_discard1 got %0d exp 0", disc1_o); end
    checks++; if (out_data1 !== RV) begin errors++; $display("FAIL reset_out_data1 got %h exp %h", out_data1, RV); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready1 got %b exp 1", in_ready1); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid0 got %b exp 0", out_valid0); end
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready0 got %b exp 1", in_ready0); end
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    logic [W-1:0] v [3];
    v[0] = 16'h000A; v[1] = 16'h000B; v[2] = 16'h000C;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, v[i], 1'b1, 1'b0, 1'b0);
      #4;
      checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL stream_in_ready1[%0d] got %b exp 1", i, in_ready1); end
      tick();
      checks++; if (out_data1 !== v[i]) begin errors++; $display("FAIL stream_out_data1[%0d] got %h exp %h", i, out_data1, v[i]); end
      checks++; if (count1 !== 2'd1) begin errors++; $display("FAIL stream_count1[%0d] got %0d exp 1", i, count1); end
      checks++; if (out_data0 !== sh0) begin errors++; $display("FAIL stream_out_data0[%0d] got %h exp %h", i, out_data0, sh0); end
    end
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #4;
    tick();
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL stream_drain_valid1 got %b exp 0", out_valid1); end
    checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL stream_drain_count1 got %0d exp 0", count1); end
  endtask

  task automatic test_skid_freeze();
    set_in(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0); #4; tick();
    set_in(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0); #4; tick();
    checks++; if (count1 !== 2'd2) begin errors++; $display("FAIL skid_count1 got %0d exp 2", count1); end
    checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL skid_in_ready1 got %b exp 0", in_ready1); end
    checks++; if (out_data1 !== 16'h0011) begin errors++; $display("FAIL skid_out_data1 got %h exp 0011", out_data1); end
    checks++; if (count0 !== 2'(q0.size())) begin errors++; $display("FAIL skid_count0 got %0d exp %0d", count0, q0.size()); end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, W'($urandom), 1'b1, 1'b1, 1'b0);
      #4;
      checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL freeze_in_ready1[%0d] got %b exp 0", i, in_ready1); end
      tick();
      checks++; if (out_data1 !== 16'h0011) begin errors++; $display("FAIL freeze_out_data1[%0d] got %h exp 0011", i, out_data1); end
      checks++; if (count1 !== 2'd2) begin errors++; $display("FAIL freeze_count1[%0d] got %0d exp 2", i, count1); end
      checks++; if (out_data0 !== sh0) begin errors++; $display("FAIL freeze_out_data0[%0d] got %h exp %h", i, out_data0, sh0); end
    end
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #4; tick();
    checks++; if (out_data1 !== 16'h0022) begin errors++; $display("FAIL drain_out_data1 got %h exp 0022", out_data1); end
    checks++; if (count1 !== 2'd1) begin errors++; $display("FAIL drain_count1 got %0d exp 1", count1); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL drain_in_ready1 got %b exp 1", in_ready1); end
    checks++; if (out_valid0 !== (q0.size() != 0)) begin errors++; $display("FAIL drain_out_valid0 got %b exp %b", out_valid0, q0.size() != 0); end
    #4; tick();
    checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL drain_empty_count1 got %0d exp 0", count1); end
  endtask

  task automatic test_flush();
    for (int r = 0; r < 201; r++) begin
      set_in(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0); #4; tick();
      set_in(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0); #4; tick();
      if (r == 0) begin
        checks++; if (count1 !== 2'd2) begin errors++; $display("FAIL flush_fill_count1 got %0d exp 2", count1); end
      end
      set_in(1'b1, W'($urandom), 1'b1, 1'b1, 1'b1); #4; tick();
      if (r == 0) begin
        checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL flush_count1 got %0d exp 0", count1); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL flush_out_valid1 got %b exp 0", out_valid1); end
        checks++; if (out_data1 !== RV) begin errors++; $display("FAIL flush_out_data1 got %h exp %h", out_data1, RV); end
        checks++; if (disc1_o !== 8'd2) begin errors++; $display("FAIL flush_discard1 got %0d exp 2", disc1_o); end
        checks++; if (out_data0 !== RV) begin errors++; $display("FAIL flush_out_data0 got %h exp %h", out_data0, RV); end
      end
      checks++; if (disc1_o !== CW'(dc1)) begin errors++; $display("FAIL flush_discard1[%0d] got %0d exp %0d", r, disc1_o, dc1); end
      checks++; if (disc0_o !== CW'(dc0)) begin errors++; $display("FAIL flush_discard0[%0d] got %0d exp %0d", r, disc0_o, dc0); end
    end
    checks++; if (disc1_o !== 8'd255) begin errors++; $display("FAIL flush_saturate1 got %0d exp 255", disc1_o); end
  endtask

  task automatic test_noskid();
    bit ordy;
    for (int i = 0; i < 8; i++) begin
      ordy = (i % 2 == 0);
      set_in(1'b1, W'($urandom), ordy, 1'b0, 1'b0);
      #4;
      checks++; if (in_ready0 !== m_rdy0()) begin errors++; $display("FAIL noskid_in_ready0[%0d] got %b exp %b", i, in_ready0, m_rdy0()); end
      out_ready = !ordy;
      #1;
      checks++; if (in_ready0 !== m_rdy0()) begin errors++; $display("FAIL noskid_comb_ready0[%0d] got %b exp %b", i, in_ready0, m_rdy0()); end
      out_ready = ordy;
      #1;
      tick();
      checks++; if (out_data0 !== sh0) begin errors++; $display("FAIL noskid_out_data0[%0d] got %h exp %h", i, out_data0, sh0); end
      checks++; if (out_valid0 !== (q0.size() != 0)) begin errors++; $display("FAIL noskid_out_valid0[%0d] got %b exp %b", i, out_valid0, q0.size() != 0); end
      checks++; if (count0 !== 2'(q0.size())) begin errors++; $display("FAIL noskid_count0[%0d] got %0d exp %0d", i, count0, q0.size()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      #4;
      checks++; if (in_ready1 !== m_rdy1()) begin errors++; $display("FAIL rnd_in_ready1[%0d] got %b exp %b", i, in_ready1, m_rdy1()); end
      checks++; if (in_ready0 !== m_rdy0()) begin errors++; $display("FAIL rnd_in_ready0[%0d] got %b exp %b", i, in_ready0, m_rdy0()); end
      tick();
      checks++; if (out_valid1 !== (q1.size() != 0)) begin errors++; $display("FAIL rnd_out_valid1[%0d] got %b exp %b", i, out_valid1, q1.size() != 0); end
      checks++; if (out_data1 !== sh1) begin errors++; $display("FAIL rnd_out_data1[%0d] got %h exp %h", i, out_data1, sh1); end
      checks++; if (count1 !== 2'(q1.size())) begin errors++; $display("FAIL rnd_count1[%0d] got %0d exp %0d", i, count1, q1.size()); end
      checks++; if (disc1_o !== CW'(dc1)) begin errors++; $display("FAIL rnd_discard1[%0d] got %0d exp %0d", i, disc1_o, dc1); end
      checks++; if (out_valid0 !== (q0.size() != 0)) begin errors++; $display("FAIL rnd_out_valid0[%0d] got %b exp %b", i, out_valid0, q0.size() != 0); end
      checks++; if (out_data0 !== sh0) begin errors++; $display("FAIL rnd_out_data0[%0d] got %h exp %h", i, out_data0, sh0); end
      checks++; if (count0 !== 2'(q0.size())) begin errors++; $display("FAIL rnd_count0[%0d] got %0d exp %0d", i, count0, q0.size()); end
      checks++; if (disc0_o !== CW'(dc0)) begin errors++; $display("FAIL rnd_discard0[%0d] got %0d exp %0d", i, disc0_o, dc0); end
    end
  endtask

  task automatic test_async_reset();
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b1); #4; tick();
    set_in(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0); #4; tick();
    set_in(1'b1, 16'h0088, 1'b0, 1'b0, 1'b0); #4; tick();
    checks++; if (count1 !== 2'd2) begin errors++; $display("FAIL areset_pre_count1 got %0d exp 2", count1); end
    checks++; if (disc1_o !== CW'(dc1)) begin errors++; $display("FAIL areset_pre_discard1 got %0d exp %0d", disc1_o, dc1); end
    #3 rst = 1'b1;
    #1;
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL areset_out_valid1 got %b exp 0", out_valid1); end
    checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL areset_count1 got %0d exp 0", count1); end
    checks++; if (disc1_o !== 8'd0) begin errors++; $display("FAIL areset_discard1 got %0d exp 0", disc1_o); end
    checks++; if (out_data1 !== RV) begin errors++; $display("FAIL areset_out_data1 got %h exp %h", out_data1, RV); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL areset_in_ready1 got %b exp 1", in_ready1); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL areset_out_valid0 got %b exp 0", out_valid0); end
    checks++; if (disc0_o !== 8'd0) begin errors++; $display("FAIL areset_discard0 got %0d exp 0", disc0_o); end
    model_reset();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_freeze();
    test_flush();
    test_noskid();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
